// File: rtl/fetch_stage.sv
// Instruction-fetch stage: holds the PC, fills the IF/ID register and predicts
// branches with a direct-mapped BTB of 2-bit saturating counters.
module fetch_stage #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     BTB_ENTRIES = 16,
    parameter logic [XLEN-1:0] RESET_PC    = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            id_pred_taken,
    output logic [XLEN-1:0] id_pred_target
);

    localparam int unsigned IDX   = $clog2(BTB_ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX - 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic [XLEN-1:0]        pc_q, pc_d;
    logic                   id_valid_q, id_valid_d;
    logic [XLEN-1:0]        id_pc_q, id_pc_d;
    logic [31:0]            id_instr_q, id_instr_d;
    logic                   id_pred_taken_q, id_pred_taken_d;
    logic [XLEN-1:0]        id_pred_target_q, id_pred_target_d;

    logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]       btb_tag_d    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target_q [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target_d [BTB_ENTRIES];
    logic [1:0]             btb_ctr_q    [BTB_ENTRIES];
    logic [1:0]             btb_ctr_d    [BTB_ENTRIES];

    logic [IDX-1:0]         lk_idx;
    logic [TAG_W-1:0]       lk_tag;
    logic                   lk_hit;
    logic                   pred_taken_c;
    logic [XLEN-1:0]        pred_target_c;
    logic [XLEN-1:0]        next_pc_c;

    logic [IDX-1:0]         up_idx;
    logic [TAG_W-1:0]       up_tag;
    logic                   up_hit;

    assign imem_addr      = pc_q;
    assign id_valid       = id_valid_q;
    assign id_pc          = id_pc_q;
    assign id_instr       = id_instr_q;
    assign id_pred_taken  = id_pred_taken_q;
    assign id_pred_target = id_pred_target_q;

    // BTB lookup on the current fetch PC (sees pre-update contents)
    always_comb begin
        lk_idx        = pc_q[IDX+1:2];
        lk_tag        = pc_q[XLEN-1:IDX+2];
        lk_hit        = btb_valid_q[lk_idx] && (btb_tag_q[lk_idx] == lk_tag);
        pred_taken_c  = lk_hit && btb_ctr_q[lk_idx][1];
        pred_target_c = pred_taken_c ? btb_target_q[lk_idx] : '0;
        next_pc_c     = pred_taken_c ? btb_target_q[lk_idx] : pc_q + XLEN'(4);
    end

    // PC and IF/ID next state: redirect beats stall beats advance
    always_comb begin
        pc_d             = pc_q;
        id_valid_d       = id_valid_q;
        id_pc_d          = id_pc_q;
        id_instr_d       = id_instr_q;
        id_pred_taken_d  = id_pred_taken_q;
        id_pred_target_d = id_pred_target_q;
        if (redirect) begin
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            id_valid_d = 1'b0;
        end else if (!stall) begin
            pc_d             = next_pc_c;
            id_valid_d       = 1'b1;
            id_pc_d          = pc_q;
            id_instr_d       = imem_rdata;
            id_pred_taken_d  = pred_taken_c;
            id_pred_target_d = pred_target_c;
        end
    end

    // BTB training from EX, independent of stall/redirect
    always_comb begin
        up_idx       = upd_pc[IDX+1:2];
        up_tag       = upd_pc[XLEN-1:IDX+2];
        up_hit       = btb_valid_q[up_idx] && (btb_tag_q[up_idx] == up_tag);
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        btb_ctr_d    = btb_ctr_q;
        for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
            if (upd_valid && (up_idx == IDX'(i))) begin
                if (up_hit) begin
                    if (upd_taken) begin
                        if (btb_ctr_q[i] != 2'b11) begin
                            btb_ctr_d[i] = btb_ctr_q[i] + 2'd1;
                        end
                        btb_target_d[i] = upd_target;
                    end else if (btb_ctr_q[i] != 2'b00) begin
                        btb_ctr_d[i] = btb_ctr_q[i] - 2'd1;
                    end
                end else if (upd_taken) begin
                    btb_valid_d[i]  = 1'b1;
                    btb_tag_d[i]    = up_tag;
                    btb_target_d[i] = upd_target;
                    btb_ctr_d[i]    = 2'b10;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            id_valid_q       <= 1'b0;
            id_pc_q          <= '0;
            id_instr_q       <= NOP;
            id_pred_taken_q  <= 1'b0;
            id_pred_target_q <= '0;
            btb_valid_q      <= '0;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
                btb_ctr_q[i]    <= 2'b01;
            end
        end else begin
            pc_q             <= pc_d;
            id_valid_q       <= id_valid_d;
            id_pc_q          <= id_pc_d;
            id_instr_q       <= id_instr_d;
            id_pred_taken_q  <= id_pred_taken_d;
            id_pred_target_q <= id_pred_target_d;
            btb_valid_q      <= btb_valid_d;
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag_q[i]    <= btb_tag_d[i];
                btb_target_q[i] <= btb_target_d[i];
                btb_ctr_q[i]    <= btb_ctr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the scenario walk-through,
// then random traffic checked against a behavioural BTB/PC model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_pred_taken;
    logic [31:0] id_pred_target;

    fetch_stage #(.XLEN(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_pred_taken (id_pred_taken),
        .id_pred_target(id_pred_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[17:2]};
    endfunction

    assign imem_rdata = memf(imem_addr);

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h at %0t", name, got, exp, $time);
    endtask

    // Behavioural model: PC, IF/ID and BTB kept as plain integers
    logic [31:0] m_pc;
    bit          m_idv;
    logic [31:0] m_idpc, m_idinstr, m_idtgt;
    bit          m_idpt;
    bit          m_bv   [16];
    logic [31:0] m_btag [16];
    logic [31:0] m_btgt [16];
    int          m_bctr [16];

    task automatic model_reset();
        m_pc = 0; m_idv = 0; m_idpc = 0; m_idinstr = 32'h13; m_idpt = 0; m_idtgt = 0;
        for (int i = 0; i < 16; i++) begin
            m_bv[i] = 0; m_btag[i] = 0; m_btgt[i] = 0; m_bctr[i] = 1;
        end
    endtask

    task automatic model_step();
        int          li, ui;
        bit          pt;
        logic [31:0] npc, tgt;
        li  = int'((m_pc / 4) % 16);
        pt  = m_bv[li] && (m_btag[li] == m_pc / 64) && (m_bctr[li] >= 2);
        tgt = pt ? m_btgt[li] : 32'h0;
        npc = pt ? m_btgt[li] : m_pc + 32'd4;
        if (redirect) begin
            m_pc  = redirect_pc & 32'hFFFF_FFFC;
            m_idv = 0;
        end else if (!stall) begin
            m_idv = 1; m_idpc = m_pc; m_idinstr = memf(m_pc); m_idpt = pt; m_idtgt = tgt;
            m_pc  = npc;
        end
        if (upd_valid) begin
            ui = int'((upd_pc / 4) % 16);
            if (m_bv[ui] && m_btag[ui] == upd_pc / 64) begin
                if (upd_taken) begin
                    m_bctr[ui] = (m_bctr[ui] == 3) ? 3 : m_bctr[ui] + 1;
                    m_btgt[ui] = upd_target;
                end else begin
                    m_bctr[ui] = (m_bctr[ui] == 0) ? 0 : m_bctr[ui] - 1;
                end
            end else if (upd_taken) begin
                m_bv[ui] = 1; m_btag[ui] = upd_pc / 64; m_btgt[ui] = upd_target; m_bctr[ui] = 2;
            end
        end
    endtask

    task automatic check_model();
        chk("m_addr",  imem_addr, m_pc);
        chk("m_valid", 32'(id_valid), 32'(m_idv));
        chk("m_pc",    id_pc, m_idpc);
        chk("m_instr", id_instr, m_idinstr);
        chk("m_pt",    32'(id_pred_taken), 32'(m_idpt));
        chk("m_ptgt",  id_pred_target, m_idtgt);
    endtask

    typedef struct {
        logic        stall, redir;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        rst_before;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_ptgt;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic s, input logic r, input logic [31:0] rpc,
                       input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
                       input logic rb, input logic [31:0] ea, input logic ev, input logic [31:0] ep,
                       input logic ept, input logic [31:0] etg);
        vec_t v;
        v.stall = s; v.redir = r; v.rpc = rpc; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
        v.rst_before = rb; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep; v.e_pt = ept; v.e_ptgt = etg;
        vt.push_back(v);
    endtask

    task automatic clear_inputs();
        stall = 0; redirect = 0; redirect_pc = 0;
        upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_addr"},  imem_addr, 32'h0);
        chk({tag, "_valid"}, 32'(id_valid), 32'h0);
        chk({tag, "_pc"},    id_pc, 32'h0);
        chk({tag, "_instr"}, id_instr, 32'h13);
        chk({tag, "_pt"},    32'(id_pred_taken), 32'h0);
        chk({tag, "_ptgt"},  id_pred_target, 32'h0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        // straight-line fetch, then 3-cycle stall
        add(0,0,0,     0,0,0,0, 0, 32'h04,1,32'h00,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h08,1,32'h04,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h0C,1,32'h08,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h10,1,32'h0C,0,0);
        for (int i = 0; i < 3; i++) add(1,0,0, 0,0,0,0, 0, 32'h10,1,32'h0C,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h14,1,32'h10,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h18,1,32'h14,0,0);
        // redirect wins over stall, low bits dropped
        add(1,1,32'h103, 0,0,0,0, 0, 32'h100,0,32'h14,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h104,1,32'h100,0,0);
        // training on 0x20 -> 0x80
        add(0,1,32'h20, 1,32'h20,1,32'h80, 0, 32'h20,0,32'h100,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h80,1,32'h20,1,32'h80);
        add(0,0,0,     1,32'h20,0,0, 0, 32'h84,1,32'h80,0,0);
        add(0,1,32'h20, 1,32'h20,0,0, 0, 32'h20,0,32'h80,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h24,1,32'h20,0,0);
        for (int i = 0; i < 5; i++)
            add(0,0,0, 1,32'h20,1,32'h80, 0, 32'h28 + 32'(4*i),1,32'h24 + 32'(4*i),0,0);
        add(0,1,32'h20, 1,32'h20,0,0, 0, 32'h20,0,32'h34,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h80,1,32'h20,1,32'h80);
        // alias 0x60 evicts 0x20 at index 8
        add(0,1,32'h20, 1,32'h60,1,32'h200, 0, 32'h20,0,32'h20,1,32'h80);
        add(0,0,0,     0,0,0,0, 0, 32'h24,1,32'h20,0,0);
        add(0,1,32'h60, 0,0,0,0, 0, 32'h60,0,32'h20,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h200,1,32'h60,1,32'h200);
        // after a mid-cycle reset the BTB is empty again
        add(0,1,32'h20, 0,0,0,0, 1, 32'h20,0,32'h0,0,0);
        add(0,0,0,     0,0,0,0, 0, 32'h24,1,32'h20,0,0);

        #3;
        check_reset_values("rst");
        #9;
        reset = 1'b0;
        model_reset();

        foreach (vt[i]) begin
            if (vt[i].rst_before) begin
                #2 reset = 1'b1;
                #1 check_reset_values("async_rst");
                model_reset();
                #2 reset = 1'b0;
            end
            stall = vt[i].stall; redirect = vt[i].redir; redirect_pc = vt[i].rpc;
            upd_valid = vt[i].uv; upd_pc = vt[i].upc; upd_taken = vt[i].ut; upd_target = vt[i].utgt;
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_addr", i),  imem_addr, vt[i].e_addr);
            chk($sformatf("v%0d_valid", i), 32'(id_valid), 32'(vt[i].e_valid));
            chk($sformatf("v%0d_pc", i),    id_pc, vt[i].e_pc);
            chk($sformatf("v%0d_pt", i),    32'(id_pred_taken), 32'(vt[i].e_pt));
            chk($sformatf("v%0d_ptgt", i),  id_pred_target, vt[i].e_ptgt);
            if (vt[i].e_valid) chk($sformatf("v%0d_instr", i), id_instr, memf(vt[i].e_pc));
            check_model();
            clear_inputs();
        end

        // random traffic against the model
        for (int c = 0; c < 600; c++) begin
            stall     = ($urandom_range(0, 3) == 0);
            redirect  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else                           redirect_pc = 32'($urandom_range(0, 511));
            upd_valid = ($urandom_range(0, 1) == 0);
            upd_pc    = ($urandom_range(0, 1) == 0) ? m_pc : (32'($urandom_range(0, 127)) << 2);
            upd_taken = ($urandom_range(0, 2) != 0);
            upd_target = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
                                                      : (32'($urandom_range(0, 127)) << 2);
            model_step();
            @(posedge clk);
            #1;
            check_model();
        end
        clear_inputs();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
